// File: rtl/multicycle_alu.sv
// Multicycle ALU: single-cycle logic/arith ops, radix-2 Booth multiply and
// non-restoring unsigned divide, sequenced by one registered-output FSM.
module multicycle_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] reg1,
  input  logic [WIDTH-1:0] reg2,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] z_high,
  output logic [WIDTH-1:0] z_low
);

  typedef enum logic [2:0] {IDLE, EXEC, MUL, DIV, DIV_FIX, DONE} state_t;

  localparam logic [SHW:0] LAST_STEP = (SHW+1)'(WIDTH);

  state_t               state_q;
  logic [3:0]           op_q;
  logic [WIDTH-1:0]     a_q, b_q;
  logic [SHW:0]         cnt_q;
  logic [2*WIDTH+1:0]   booth_q, booth_d;
  logic [WIDTH+1:0]     rem_q, rem_d;
  logic [WIDTH-1:0]     quo_q, quo_d;
  logic [WIDTH-1:0]     rem_fix;
  logic                 busy_q, done_q, dz_q;
  logic [WIDTH-1:0]     zh_q, zl_q;

  logic [WIDTH:0]       acc, mcand, acc_sum;
  logic [WIDTH+1:0]     rem_sh, dvs;

  function automatic logic [WIDTH-1:0] exec_result(input logic [3:0] f_op,
                                                   input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b);
    logic [SHW-1:0] amt;
    logic [SHW:0]   rev;
    amt = b[SHW-1:0];
    rev = LAST_STEP - {1'b0, amt};
    case (f_op)
      4'd2:    return a + b;
      4'd3:    return a - b;
      4'd4:    return a << amt;
      4'd5:    return a >> amt;
      // a shifted by WIDTH yields 0, so amount 0 returns a unchanged
      4'd6:    return (a >> amt) | (a << rev);
      4'd7:    return (a << amt) | (a >> rev);
      4'd8:    return a | b;
      4'd9:    return '0 - b;
      4'd10:   return a & b;
      4'd11:   return ~b;
      4'd12:   return WIDTH'($signed(a) >>> amt);
      default: return '0;
    endcase
  endfunction

  // Booth register layout: {acc[WIDTH:0], multiplier[WIDTH-1:0], q_minus1}
  always_comb begin
    acc   = booth_q[2*WIDTH+1:WIDTH+1];
    mcand = {a_q[WIDTH-1], a_q};
    case (booth_q[1:0])
      2'b01:   acc_sum = acc + mcand;
      2'b10:   acc_sum = acc - mcand;
      default: acc_sum = acc;
    endcase
    booth_d = {acc_sum[WIDTH], acc_sum, booth_q[WIDTH:1]};

    // remainder carries two extra bits so 2R +/- D never wraps
    dvs     = {2'b00, b_q};
    rem_sh  = {rem_q[WIDTH:0], quo_q[WIDTH-1]};
    rem_d   = rem_q[WIDTH+1] ? rem_sh + dvs : rem_sh - dvs;
    quo_d   = {quo_q[WIDTH-2:0], ~rem_d[WIDTH+1]};
    rem_fix = rem_q[WIDTH+1] ? rem_q[WIDTH-1:0] + b_q : rem_q[WIDTH-1:0];
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      booth_q <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      zh_q    <= '0;
      zl_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            op_q   <= op;
            a_q    <= reg1;
            b_q    <= reg2;
            cnt_q  <= '0;
            busy_q <= 1'b1;
            if (op == 4'd0 && reg2 != '0) state_q <= DIV;
            else if (op == 4'd1)          state_q <= MUL;
            else                          state_q <= EXEC;
          end
        end
        EXEC: begin
          state_q <= DONE;
          done_q  <= 1'b1;
          if (op_q == 4'd0) begin
            zh_q <= a_q;
            zl_q <= '1;
            dz_q <= 1'b1;
          end else begin
            zh_q <= '0;
            zl_q <= exec_result(op_q, a_q, b_q);
            dz_q <= 1'b0;
          end
        end
        // first cycle loads the working register, then one step per cycle
        MUL: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == '0) begin
            booth_q <= {{(WIDTH+1){1'b0}}, b_q, 1'b0};
          end else begin
            booth_q <= booth_d;
            if (cnt_q == LAST_STEP) begin
              state_q      <= DONE;
              done_q       <= 1'b1;
              dz_q         <= 1'b0;
              {zh_q, zl_q} <= booth_d[2*WIDTH:1];
            end
          end
        end
        DIV: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == '0) begin
            rem_q <= '0;
            quo_q <= a_q;
          end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            if (cnt_q == LAST_STEP) state_q <= DIV_FIX;
          end
        end
        DIV_FIX: begin
          state_q <= DONE;
          done_q  <= 1'b1;
          dz_q    <= 1'b0;
          zl_q    <= quo_q;
          zh_q    <= rem_fix;
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;
  assign z_high   = zh_q;
  assign z_low    = zl_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// Scoreboard bench for multicycle_alu (WIDTH=32): behavioural reference model,
// latency measurement, busy-time start pulses and reset mid-divide.
module tb_multicycle_alu;

  localparam int W = 32;

  logic          Clk = 1'b0;
  logic          Reset_n;
  logic          start;
  logic [3:0]    op;
  logic [W-1:0]  reg1, reg2;
  logic          busy, done, div_zero;
  logic [W-1:0]  z_high, z_low;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           lat;
  } exp_t;

  exp_t exp_q[$];

  multicycle_alu #(.WIDTH(W)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .start(start), .op(op),
    .reg1(reg1), .reg2(reg2), .busy(busy), .done(done),
    .div_zero(div_zero), .z_high(z_high), .z_low(z_low)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    logic [4:0]  amt;
    logic signed [63:0] p;
    amt   = b[4:0];
    e.hi  = '0;
    e.lo  = '0;
    e.dz  = 1'b0;
    e.lat = 2;
    case (o)
      4'd0: begin
        if (b == 0) begin
          e.hi = a; e.lo = '1; e.dz = 1'b1;
        end else begin
          e.hi = a % b; e.lo = a / b; e.lat = W + 3;
        end
      end
      4'd1: begin
        p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        {e.hi, e.lo} = p;
        e.lat = W + 2;
      end
      4'd2:  e.lo = a + b;
      4'd3:  e.lo = a - b;
      4'd4:  e.lo = a << amt;
      4'd5:  e.lo = a >> amt;
      4'd6:  e.lo = (amt == 0) ? a : ((a >> amt) | (a << (6'd32 - amt)));
      4'd7:  e.lo = (amt == 0) ? a : ((a << amt) | (a >> (6'd32 - amt)));
      4'd8:  e.lo = a | b;
      4'd9:  e.lo = ~b + 1;
      4'd10: e.lo = a & b;
      4'd11: e.lo = ~b;
      4'd12: e.lo = $signed(a) >>> amt;
      default: e.lo = '0;
    endcase
    return e;
  endfunction

  // pulse_at > 0 raises start for one cycle while the operation is busy
  task automatic run_op(input string tag, input logic [3:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int pulse_at);
    exp_t e;
    int   lat;
    int   spurious;
    exp_q.push_back(model(o, a, b));
    @(negedge Clk);
    start = 1'b1; op = o; reg1 = a; reg2 = b;
    @(posedge Clk);
    @(negedge Clk);
    start = 1'b0; op = 4'($urandom_range(0, 15)); reg1 = $urandom; reg2 = $urandom;
    check({tag, "_busy"}, 64'(busy), 64'd1);
    lat = 0;
    for (int k = 1; k <= 200; k++) begin
      if (pulse_at > 0 && k == pulse_at) begin
        start = 1'b1; op = 4'd2;
      end else begin
        start = 1'b0;
      end
      @(posedge Clk);
      @(negedge Clk);
      if (done) begin
        lat = k + 1;
        break;
      end
    end
    start = 1'b0;
    e = exp_q.pop_front();
    check({tag, "_lat"}, 64'(lat), 64'(e.lat));
    check({tag, "_zhigh"}, 64'(z_high), 64'(e.hi));
    check({tag, "_zlow"}, 64'(z_low), 64'(e.lo));
    check({tag, "_divzero"}, 64'(div_zero), 64'(e.dz));
    spurious = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge Clk);
      @(negedge Clk);
      if (done || busy) spurious++;
      if (z_high !== e.hi || z_low !== e.lo || div_zero !== e.dz) spurious++;
    end
    check({tag, "_idle_hold"}, 64'(spurious), 64'd0);
  endtask

  initial begin
    int seen_done;
    Reset_n = 1'b0; start = 1'b0; op = '0; reg1 = '0; reg2 = '0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    check("rst_out", {busy, done, div_zero, z_high[28:0], z_low}, 64'd0);
    Reset_n = 1'b1;

    run_op("add_wrap", 4'd2, 32'hFFFF_FFFF, 32'd1, 0);
    run_op("mul_neg", 4'd1, 32'hFFFF_FFFD, 32'd7, 0);
    run_op("div_100_7", 4'd0, 32'd100, 32'd7, 0);
    run_op("div_zero", 4'd0, 32'd5, 32'd0, 0);
    run_op("rol1", 4'd7, 32'h8000_0001, 32'h21, 0);
    run_op("ror0", 4'd6, 32'h1234_5678, 32'd0, 0);
    run_op("mul_minmin", 4'd1, 32'h8000_0000, 32'h8000_0000, 0);
    run_op("div_big", 4'd0, 32'hFFFF_FFFF, 32'h8000_0001, 0);
    run_op("sub_wrap", 4'd3, 32'd0, 32'd1, 0);
    run_op("asr", 4'd12, 32'h8000_0F00, 32'd36, 0);
    run_op("mul_pulse", 4'd1, 32'd1234, 32'hFFFF_F000, 5);

    for (int i = 0; i < 16; i++) begin
      logic [3:0]   ro;
      logic [W-1:0] rb;
      ro = 4'(i);
      rb = (ro == 4'd0) ? 32'($urandom_range(1, 1000)) : $urandom;
      run_op($sformatf("rnd_op%0d", i), ro, $urandom, rb, 0);
    end

    // reset asserted in the middle of a divide
    @(negedge Clk);
    start = 1'b1; op = 4'd0; reg1 = 32'd1000; reg2 = 32'd3;
    @(posedge Clk);
    @(negedge Clk);
    start = 1'b0;
    seen_done = 0;
    for (int k = 1; k < 10; k++) begin
      @(posedge Clk);
      @(negedge Clk);
      if (done) seen_done++;
    end
    #2 Reset_n = 1'b0;
    #1 check("rst_mid_out", {busy, done, div_zero, z_high[28:0], z_low}, 64'd0);
    check("rst_mid_zhigh", 64'(z_high), 64'd0);
    for (int k = 0; k < 3; k++) begin
      @(posedge Clk);
      if (done) seen_done++;
    end
    @(negedge Clk);
    Reset_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge Clk);
      @(negedge Clk);
      if (done) seen_done++;
    end
    check("rst_mid_nodone", 64'(seen_done), 64'd0);
    run_op("add_after_rst", 4'd2, 32'd40, 32'd2, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
